// File: rtl/seq_divider_32bit.sv
// Sequential 32-bit restoring divider, signed and unsigned.
// One quotient bit per cycle; zero-divisor and overflow finish early.
module seq_divider_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;

  logic [32:0] sh;
  logic [32:0] diff;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        ovf;

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    q_d     = q_q;
    r_d     = r_q;

    sh    = {rem_q, quo_q[31]};
    diff  = sh - {1'b0, dvs_q};
    rem_n = diff[32] ? sh[31:0] : diff[31:0];
    quo_n = {quo_q[30:0], ~diff[32]};

    abs_a = (is_signed && a[31]) ? -a : a;
    abs_b = (is_signed && b[31]) ? -b : b;
    ovf   = is_signed && (a == 32'h8000_0000)
            && (b == 32'hFFFF_FFFF);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_q_d = is_signed && (a[31] ^ b[31]);
          neg_r_d = is_signed && a[31];
          if (b == 32'd0) begin
            q_d     = 32'hFFFF_FFFF;
            r_d     = a;
            state_d = DONE;
          end else if (ovf) begin
            q_d     = 32'h8000_0000;
            r_d     = 32'd0;
            state_d = DONE;
          end else begin
            rem_d   = 32'd0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            cnt_d   = 5'd0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          q_d     = neg_q_q ? -quo_n : quo_n;
          r_d     = neg_r_q ? -rem_n : rem_n;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Scoreboard bench for seq_divider_32bit.
// Driver pushes expected results; monitor pops on done.
module tb_seq_divider_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;

  seq_divider_32bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_signed(is_signed),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .q(q),
    .r(r)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic s);
    exp_t e;
    e.acc = 0;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = x; e.lat = 1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
    end else if (s) begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
      e.lat = 33;
    end else begin
      e.q = x / y; e.r = x % y; e.lat = 33;
    end
    return e;
  endfunction

  // Monitor: compare each done against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done q=%h r=%h", q, r);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        lat = cyc - e.acc + 1;
        if (q !== e.q || r !== e.r || lat != e.lat) begin
          errors++;
          $display("FAIL result got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d",
                   q, r, lat, e.q, e.r, e.lat);
        end
        last_q = e.q;
        last_r = e.r;
      end
    end else if (rst_n && !busy) begin
      checks++;
      if (q !== last_q || r !== last_r) begin
        errors++;
        $display("FAIL hold got q=%h r=%h exp q=%h r=%h",
                 q, r, last_q, last_r);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%b exp 0", busy);
    end
  endtask

  // Issue one op; optionally poke start at busy cycle poke.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic s, input int poke);
    exp_t e;
    int   n;
    wait_idle();
    a = x; b = y; is_signed = s; start = 1'b1;
    e = model(x, y, s);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        start = 1'b0;
        break;
      end
      n++;
      start = (n == poke) || done;
      if (start) begin
        a = $urandom; b = $urandom_range(1, 9);
        is_signed = 1'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (n != e.lat || busy) begin
      errors++;
      $display("FAIL busy_len got %0d exp %0d", n, e.lat);
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    a = 32'd0; b = 32'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b q=%h r=%h exp all 0",
               busy, done, q, r);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'h1234_5678, 32'd0, 1'b0, 0);
    do_op(32'h1234_5678, 32'd0, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0);
    do_op(32'd5, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(32'd1000, 32'd3, 1'b0, 10);
    do_op(32'h8000_0000, 32'd3, 1'b1, 0);

    // Reset in the middle of a calculation.
    wait_idle();
    a = 32'd999; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    last_q = 32'd0;
    last_r = 32'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b q=%h r=%h exp all 0",
               busy, done, q, r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    do_op(32'd999, 32'd5, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = -($urandom_range(1, 15));
        3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: y = $urandom;
      endcase
      do_op(x, y, s, (i % 4 == 0) ? int'($urandom_range(1, 30)) : 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_32bit.md
SEQ_DIVIDER_32BIT -- requirements
Module: seq_divider_32bit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
REQ-007 a  input  32  dividend; sampled with start.
REQ-008 b  input  32  divisor; sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when q and r are valid.
REQ-011 q  output  32  quotient.
REQ-012 r  output  32  remainder.

Function
REQ-013 States SHALL be IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a, b and is_signed, then transition on the same edge:
- to DONE if b==0 or a signed overflow case is detected;
- to CALC otherwise.
REQ-015 In CALC, the block SHALL perform one restoring shift-subtract step per cycle on magnitudes for exactly 32 cycles, then enter DONE.
REQ-016 Each CALC step SHALL:
- shift {rem,quo} left by 1;
- compute rem-divisor with a 33-bit subtract;
- if the difference is non-negative, keep the difference and set quo[0]=1;
- otherwise restore rem and set quo[0]=0.
REQ-017 In DONE, the block SHALL assert done for exactly one cycle, drive the final q and r, then return to IDLE.
REQ-018 Latency from the start-accept edge to the done cycle SHALL be:
- 33 cycles for the normal path;
- 1 cycle for the divide-by-zero and overflow paths.
REQ-019 In signed mode, the block SHALL divide magnitudes and then apply sign correction:
- q is negated when sign(a) differs from sign(b);
- r takes the sign of a.
REQ-020 Divide by zero (b==0) SHALL give q=32'hFFFFFFFF and r=a, in both signed and unsigned modes.
REQ-021 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF, is_signed=1) SHALL give q=32'h80000000 and r=0.
REQ-022 start asserted while busy=1 SHALL be ignored, and the in-progress operation SHALL be unaffected.
REQ-023 Changes on a, b and is_signed after the start-accept edge SHALL NOT affect the result.
REQ-024 q and r SHALL hold their last result from done until the next done; they are undefined-free but not required to be stable while busy.
REQ-025 start asserted in the cycle done=1 SHALL be ignored; a new start SHALL be accepted on the next cycle, which is in IDLE.
REQ-026 Back-to-back operations SHALL be possible with one IDLE cycle between done and the next accept.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- busy=0 and done=0;
- q=0 and r=0;
- all internal registers to 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge on which start=1.

Verification
REQ-030 Unsigned: a=100, b=7, is_signed=0 -> done 33 cycles after accept; q=14, r=2; busy high for 33 cycles.
REQ-031 Signed: a=-7 (32'hFFFFFFF9), b=2, is_signed=1 -> q=-3 (32'hFFFFFFFD), r=-1 (32'hFFFFFFFF).
REQ-032 Special cases, each with done 1 cycle after accept:
- a=32'h12345678, b=0 -> q=32'hFFFFFFFF, r=32'h12345678;
- a=32'h80000000, b=-1, is_signed=1 -> q=32'h80000000, r=0.
REQ-033 Unsigned max: a=32'hFFFFFFFF, b=1, is_signed=0 -> q=32'hFFFFFFFF, r=0.
- Same operands with is_signed=1 -> q=32'hFFFFFFFF, r=0.
REQ-034 Start during busy: issue start at CALC cycle 10 with different operands -> the first result is unchanged; the second start is not executed.
REQ-035 Reset mid-CALC: pull rst_n low at CALC cycle 15 -> busy=0, q=0, r=0 immediately; no done pulse; the next operation completes correctly.
